// File: rtl/local_endpoint_if.sv
// User-side and router-side signal bundle of a local endpoint.
// The endpoint takes the master modport. The environment (user logic plus
// the router's Local port) takes the slave modport.
interface local_endpoint_if #(
  parameter int SIZE = 8
);
  logic            send_valid;
  logic [SIZE-1:0] send_data;
  logic            send_ready;
  logic            out_req;
  logic            out_ack;
  logic [SIZE-1:0] out_data;
  logic            in_req;
  logic            in_ack;
  logic [SIZE-1:0] in_data;
  logic            recv_valid;
  logic [SIZE-1:0] recv_data;
  logic            recv_read;
  logic [15:0]     sent_count;
  logic [15:0]     recv_count;

  modport master (
    input  send_valid, send_data, out_ack, in_req, in_data, recv_read,
    output send_ready, out_req, out_data, in_ack, recv_valid, recv_data,
           sent_count, recv_count
  );

  modport slave (
    output send_valid, send_data, out_ack, in_req, in_data, recv_read,
    input  send_ready, out_req, out_data, in_ack, recv_valid, recv_data,
           sent_count, recv_count
  );
endinterface

// File: rtl/local_endpoint.sv
// Local endpoint of a NoC router.
// The user pushes flits into a TX circular queue. The TX FSM drains that queue
// over a four-phase req/ack link into the router. The RX FSM takes flits from
// the router over a second four-phase link into an RX circular queue, which
// the user reads. The TX and RX paths run independently.
module local_endpoint #(
  parameter int ID         = -1,
  parameter int SIZE       = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input logic              clk,
  input logic              reset,
  local_endpoint_if.master bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_REL  = 2'd2;
  localparam logic [0:0] R_WAIT = 1'b0;
  localparam logic [0:0] R_ACK  = 1'b1;

  // ID only identifies which router this endpoint sits on. Values below -1
  // have no meaning, and nothing is built for them.
  if (ID < -1) begin : g_invalid_id
  end

  // ---------------- TX path ----------------
  logic [SIZE-1:0]       tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  tx_push, tx_pop;
  logic [1:0]            tx_state;
  logic                  out_req_reg;
  logic [SIZE-1:0]       out_data_reg;
  logic [15:0]           sent_count_reg;

  // send_ready depends only on the registered occupancy, so a pop in the same
  // cycle never opens the queue combinationally.
  assign bus.send_ready = (tx_count != FULL_COUNT);
  assign tx_push        = !reset && bus.send_valid && bus.send_ready;
  assign tx_pop         = !reset && (tx_state == T_REQ) && bus.out_ack;
  assign bus.out_req    = out_req_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.sent_count = sent_count_reg;

  // TX storage: write only, with no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.send_data;
  end

  // TX pointers wrap modulo the depth. Occupancy tracks pushes minus pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + (DEPTH_LOG2 + 1)'(tx_push) - (DEPTH_LOG2 + 1)'(tx_pop);
    end
  end

  // TX handshake. The head is registered into out_data when the request
  // rises, and it stays frozen until the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state       <= T_IDLE;
      out_req_reg    <= 1'b0;
      out_data_reg   <= '0;
      sent_count_reg <= '0;
    end else begin
      case (tx_state)
        T_IDLE: if (tx_count != '0) begin
          out_req_reg  <= 1'b1;
          out_data_reg <= tx_mem[tx_rd_ptr];
          tx_state     <= T_REQ;
        end
        T_REQ: if (bus.out_ack) begin
          out_req_reg    <= 1'b0;
          sent_count_reg <= sent_count_reg + 16'd1;
          tx_state       <= T_REL;
        end
        T_REL: if (!bus.out_ack) tx_state <= T_IDLE;
        default: begin
          out_req_reg <= 1'b0;
          tx_state    <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [SIZE-1:0]       rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_push, rx_pop, rx_space;
  logic [0:0]            rx_state;
  logic                  in_ack_reg;
  logic [15:0]           recv_count_reg;

  // A read in the same cycle frees a slot, so a full queue can still accept.
  assign bus.recv_valid = (rx_count != '0);
  assign bus.recv_data  = rx_mem[rx_rd_ptr];
  assign rx_pop         = !reset && bus.recv_read && bus.recv_valid;
  assign rx_space       = (rx_count != FULL_COUNT) || rx_pop;
  assign rx_push        = !reset && (rx_state == R_WAIT) && bus.in_req && rx_space;
  assign bus.in_ack     = in_ack_reg;
  assign bus.recv_count = recv_count_reg;

  // RX storage: captures the incoming flit when it is accepted.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.in_data;
  end

  // RX pointers and occupancy, handled the same way as on the TX side.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + (DEPTH_LOG2 + 1)'(rx_push) - (DEPTH_LOG2 + 1)'(rx_pop);
    end
  end

  // Received-flit counter. It is reloaded every cycle and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) recv_count_reg <= '0;
    else       recv_count_reg <= recv_count_reg + {15'd0, rx_push};
  end

  // RX handshake. ack rises with the capture and falls once req is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= R_WAIT;
      in_ack_reg <= 1'b0;
    end else begin
      case (rx_state)
        R_WAIT: if (rx_push) begin
          in_ack_reg <= 1'b1;
          rx_state   <= R_ACK;
        end
        default: if (!bus.in_req) begin
          in_ack_reg <= 1'b0;
          rx_state   <= R_WAIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_local_endpoint.sv
// Bench for local_endpoint with SIZE=8 and DEPTH_LOG2=2.
// The bench plays both the user and the router. It checks the outputs against
// queue models of the TX and RX buffers and the four-phase link rules.
module tb_local_endpoint;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  int          pass_count  = 0;
  int          check_count = 0;
  logic [15:0] exp_sent, exp_recv;

  local_endpoint_if #(.SIZE(SIZE)) bus ();

  local_endpoint #(.ID(3), .SIZE(SIZE), .DEPTH_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.send_valid = 1'b1; bus.send_data = 8'h55; bus.out_ack = 1'b0;
    bus.in_req = 1'b1; bus.in_data = 8'hAA; bus.recv_read = 1'b1;
    tick(); tick();
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL reset_out_req: got %b want 0", bus.out_req); else pass_count++;
    check_count++; if (bus.in_ack !== 1'b0) $display("FAIL reset_in_ack: got %b want 0", bus.in_ack); else pass_count++;
    check_count++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data); else pass_count++;
    check_count++; if (bus.sent_count !== 16'd0) $display("FAIL reset_sent_count: got %0d want 0", bus.sent_count); else pass_count++;
    check_count++; if (bus.recv_count !== 16'd0) $display("FAIL reset_recv_count: got %0d want 0", bus.recv_count); else pass_count++;
    check_count++; if (bus.send_ready !== 1'b1) $display("FAIL reset_send_ready: got %b want 1", bus.send_ready); else pass_count++;
    check_count++; if (bus.recv_valid !== 1'b0) $display("FAIL reset_recv_valid: got %b want 0", bus.recv_valid); else pass_count++;
    reset = 1'b0; bus.send_valid = 1'b0; bus.in_req = 1'b0; bus.recv_read = 1'b0;
    tick(); tick();
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL reset_ignored_push: out_req got %b want 0", bus.out_req); else pass_count++;
    check_count++; if (bus.recv_valid !== 1'b0) $display("FAIL reset_ignored_rx: recv_valid got %b want 0", bus.recv_valid); else pass_count++;
    exp_sent = 16'd0; exp_recv = 16'd0;
    $display("reset: outputs at reset values, inputs ignored during reset");
  endtask

  task automatic test_single_send();
    bus.send_valid = 1'b1; bus.send_data = 8'h3A;
    tick();
    bus.send_valid = 1'b0;
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL single_req_early: got %b want 0", bus.out_req); else pass_count++;
    tick();
    check_count++; if (bus.out_req !== 1'b1) $display("FAIL single_req_rise: got %b want 1", bus.out_req); else pass_count++;
    check_count++; if (bus.out_data !== 8'h3A) $display("FAIL single_data: got %h want 3a", bus.out_data); else pass_count++;
    tick();
    check_count++; if (bus.out_req !== 1'b1 || bus.out_data !== 8'h3A) $display("FAIL single_hold: req %b data %h want 1 3a", bus.out_req, bus.out_data); else pass_count++;
    bus.out_ack = 1'b1;
    tick();
    exp_sent++;
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL single_req_fall: got %b want 0", bus.out_req); else pass_count++;
    check_count++; if (bus.sent_count !== exp_sent) $display("FAIL single_sent_count: got %0d want %0d", bus.sent_count, exp_sent); else pass_count++;
    bus.out_ack = 1'b0;
    tick(); tick();
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL single_no_repeat: out_req got %b want 0", bus.out_req); else pass_count++;
    $display("tx flit 3a sent, sent_count=%0d", bus.sent_count);
  endtask

  task automatic test_tx_backpressure();
    logic [SIZE-1:0] d [5];
    logic [SIZE-1:0] q [$];
    logic [15:0]     base_sent;
    bit              pending, push_now, pop_now;
    for (int i = 0; i < 5; i++) d[i] = SIZE'($urandom);
    bus.out_ack = 1'b0;
    base_sent = exp_sent;
    for (int i = 0; i < 4; i++) begin
      bus.send_valid = 1'b1; bus.send_data = d[i];
      tick();
      check_count++;
      if (bus.send_ready !== (i < 3)) $display("FAIL txbp_ready_%0d: got %b want %b", i, bus.send_ready, (i < 3));
      else pass_count++;
    end
    bus.send_data = d[4];
    tick(); tick(); tick();
    check_count++; if (bus.send_ready !== 1'b0) $display("FAIL txbp_hold_ready: got %b want 0", bus.send_ready); else pass_count++;
    check_count++; if (bus.sent_count !== exp_sent) $display("FAIL txbp_hold_count: got %0d want %0d", bus.sent_count, exp_sent); else pass_count++;
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(d[i]);
    pending = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (q.size() == 0 && !pending && !bus.out_req && !bus.out_ack) break;
      if (bus.out_req && !bus.out_ack) begin
        check_count++;
        if (q.size() == 0 || bus.out_data !== q[0]) $display("FAIL txbp_order: got %h want %h", bus.out_data, (q.size() > 0) ? q[0] : 8'hxx);
        else pass_count++;
        $display("tx flit %h delivered", bus.out_data);
        bus.out_ack = 1'b1;
      end else if (!bus.out_req && bus.out_ack) begin
        bus.out_ack = 1'b0;
      end
      push_now = bus.send_valid && bus.send_ready;
      pop_now  = bus.out_req && bus.out_ack;
      tick();
      if (pop_now && q.size() > 0) begin void'(q.pop_front()); exp_sent++; end
      if (push_now) begin
        check_count++;
        if (exp_sent == base_sent) $display("FAIL txbp_fifth_early: accepted with sent_count %0d", bus.sent_count);
        else pass_count++;
        q.push_back(d[4]);
        bus.send_valid = 1'b0;
        pending = 1'b0;
      end
    end
    check_count++; if (q.size() != 0 || pending) $display("FAIL txbp_drain: %0d flits left, pending %b", q.size(), pending); else pass_count++;
    check_count++; if (bus.sent_count !== exp_sent) $display("FAIL txbp_sent_count: got %0d want %0d", bus.sent_count, exp_sent); else pass_count++;
  endtask

  task automatic test_rx_backpressure();
    logic [SIZE-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = SIZE'($urandom);
    bus.recv_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_req = 1'b1; bus.in_data = d[i];
      tick();
      exp_recv++;
      check_count++; if (bus.in_ack !== 1'b1) $display("FAIL rxbp_ack_%0d: got %b want 1", i, bus.in_ack); else pass_count++;
      bus.in_req = 1'b0;
      tick();
      check_count++; if (bus.in_ack !== 1'b0) $display("FAIL rxbp_ack_fall_%0d: got %b want 0", i, bus.in_ack); else pass_count++;
      $display("rx flit %h accepted, recv_count=%0d", d[i], bus.recv_count);
    end
    bus.in_req = 1'b1; bus.in_data = d[4];
    tick(); tick(); tick();
    check_count++; if (bus.in_ack !== 1'b0) $display("FAIL rxbp_full_ack: got %b want 0", bus.in_ack); else pass_count++;
    check_count++; if (bus.recv_count !== exp_recv) $display("FAIL rxbp_full_count: got %0d want %0d", bus.recv_count, exp_recv); else pass_count++;
    check_count++; if (bus.recv_data !== d[0]) $display("FAIL rxbp_head: got %h want %h", bus.recv_data, d[0]); else pass_count++;
    bus.recv_read = 1'b1;
    tick();
    bus.recv_read = 1'b0;
    exp_recv++;
    check_count++; if (bus.in_ack !== 1'b1) $display("FAIL rxbp_read_ack: got %b want 1", bus.in_ack); else pass_count++;
    check_count++; if (bus.recv_count !== exp_recv) $display("FAIL rxbp_read_count: got %0d want %0d", bus.recv_count, exp_recv); else pass_count++;
    $display("rx flit %h accepted at full with concurrent read", d[4]);
    bus.in_req = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) begin
      check_count++;
      if (bus.recv_valid !== 1'b1 || bus.recv_data !== d[i]) $display("FAIL rxbp_read_%0d: valid %b data %h want 1 %h", i, bus.recv_valid, bus.recv_data, d[i]);
      else pass_count++;
      bus.recv_read = 1'b1;
      tick();
      bus.recv_read = 1'b0;
    end
    check_count++; if (bus.recv_valid !== 1'b0) $display("FAIL rxbp_empty: got %b want 0", bus.recv_valid); else pass_count++;
  endtask

  task automatic test_counter_wrap();
    force dut.recv_count_reg = 16'hFFFE;
    tick();
    release dut.recv_count_reg;
    exp_recv = 16'hFFFE;
    check_count++; if (bus.recv_count !== exp_recv) $display("FAIL wrap_preload: got %h want %h", bus.recv_count, exp_recv); else pass_count++;
    for (int i = 0; i < 2; i++) begin
      bus.in_req = 1'b1; bus.in_data = SIZE'(8'hE0 + i);
      tick();
      exp_recv++;
      bus.in_req = 1'b0;
      check_count++; if (bus.recv_count !== exp_recv) $display("FAIL wrap_count_%0d: got %h want %h", i, bus.recv_count, exp_recv); else pass_count++;
      tick();
      bus.recv_read = 1'b1;
      tick();
      bus.recv_read = 1'b0;
      $display("rx flit %h accepted, recv_count=%h", 8'hE0 + i, bus.recv_count);
    end
  endtask

  task automatic test_random_traffic();
    logic [SIZE-1:0] tx_q [$];
    logic [SIZE-1:0] rx_q [$];
    bit tx_push, tx_pop, rx_pop, gen;
    bit pre_in_req, pre_in_ack, pre_out_req, pre_out_ack, exp_in_ack;
    int pre_rx_size;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      gen = (cyc < 3000);
      if (!gen && tx_q.size() == 0 && rx_q.size() == 0 && !bus.out_req && !bus.out_ack && !bus.in_req && !bus.in_ack) break;
      bus.send_valid = gen && ($urandom_range(0, 2) != 0);
      bus.send_data  = SIZE'($urandom);
      bus.recv_read  = !gen || ($urandom_range(0, 2) == 0);
      if (bus.in_req && bus.in_ack) begin
        if ($urandom_range(0, 1) == 1) bus.in_req = 1'b0;
      end else if (!bus.in_req && !bus.in_ack && gen && $urandom_range(0, 2) == 0) begin
        bus.in_req = 1'b1; bus.in_data = SIZE'($urandom);
      end
      if (bus.out_req) begin
        check_count++;
        if (tx_q.size() == 0 || bus.out_data !== tx_q[0]) $display("FAIL rnd_out_data: got %h want %h", bus.out_data, (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
        else pass_count++;
        if (!bus.out_ack && $urandom_range(0, 1) == 1) bus.out_ack = 1'b1;
      end else if (bus.out_ack && $urandom_range(0, 1) == 1) begin
        bus.out_ack = 1'b0;
      end
      tx_push = bus.send_valid && bus.send_ready;
      tx_pop  = bus.out_req && bus.out_ack;
      rx_pop  = bus.recv_read && bus.recv_valid;
      pre_in_req = bus.in_req; pre_in_ack = bus.in_ack;
      pre_out_req = bus.out_req; pre_out_ack = bus.out_ack;
      pre_rx_size = rx_q.size();
      tick();
      if (tx_pop && tx_q.size() > 0) begin void'(tx_q.pop_front()); exp_sent++; end
      if (tx_push) tx_q.push_back(bus.send_data);
      if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
      exp_in_ack = pre_in_ack ? pre_in_req : (pre_in_req && (pre_rx_size < DEPTH || rx_pop));
      check_count++; if (bus.in_ack !== exp_in_ack) $display("FAIL rnd_in_ack: got %b want %b", bus.in_ack, exp_in_ack); else pass_count++;
      if (!pre_in_ack && exp_in_ack) begin rx_q.push_back(bus.in_data); exp_recv++; end
      if (pre_out_req) begin
        check_count++; if (bus.out_req !== !pre_out_ack) $display("FAIL rnd_out_req: got %b want %b", bus.out_req, !pre_out_ack); else pass_count++;
      end else if (bus.out_req) begin
        check_count++; if (pre_out_ack) $display("FAIL rnd_req_during_ack: got req 1 while ack 1 want 0"); else pass_count++;
      end
      check_count++; if (bus.send_ready !== (tx_q.size() < DEPTH)) $display("FAIL rnd_send_ready: got %b want %b", bus.send_ready, (tx_q.size() < DEPTH)); else pass_count++;
      check_count++; if (bus.sent_count !== exp_sent) $display("FAIL rnd_sent_count: got %0d want %0d", bus.sent_count, exp_sent); else pass_count++;
      check_count++; if (bus.recv_count !== exp_recv) $display("FAIL rnd_recv_count: got %0d want %0d", bus.recv_count, exp_recv); else pass_count++;
      check_count++; if (bus.recv_valid !== (rx_q.size() != 0)) $display("FAIL rnd_recv_valid: got %b want %b", bus.recv_valid, (rx_q.size() != 0)); else pass_count++;
      if (rx_q.size() != 0) begin
        check_count++; if (bus.recv_data !== rx_q[0]) $display("FAIL rnd_recv_data: got %h want %h", bus.recv_data, rx_q[0]); else pass_count++;
      end
    end
    bus.send_valid = 1'b0; bus.recv_read = 1'b0;
    check_count++;
    if (tx_q.size() != 0 || rx_q.size() != 0) $display("FAIL rnd_drain: tx left %0d rx left %0d want 0 0", tx_q.size(), rx_q.size());
    else pass_count++;
    $display("random traffic: sent_count=%0d recv_count=%0d", bus.sent_count, bus.recv_count);
  endtask

  task automatic test_reset_midflight();
    bus.out_ack = 1'b0; bus.in_req = 1'b0; bus.recv_read = 1'b0;
    tick();
    bus.send_valid = 1'b1; bus.send_data = 8'hC3;
    tick();
    bus.send_data = 8'h3C;
    tick();
    bus.send_valid = 1'b0;
    bus.in_req = 1'b1; bus.in_data = 8'h99;
    tick();
    check_count++; if (bus.out_req !== 1'b1 || bus.in_ack !== 1'b1) $display("FAIL mid_setup: req %b ack %b want 1 1", bus.out_req, bus.in_ack); else pass_count++;
    reset = 1'b1; bus.send_valid = 1'b1; bus.send_data = 8'h77;
    tick();
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL mid_out_req: got %b want 0", bus.out_req); else pass_count++;
    check_count++; if (bus.in_ack !== 1'b0) $display("FAIL mid_in_ack: got %b want 0", bus.in_ack); else pass_count++;
    check_count++; if (bus.out_data !== 8'h00) $display("FAIL mid_out_data: got %h want 00", bus.out_data); else pass_count++;
    check_count++; if (bus.sent_count !== 16'd0 || bus.recv_count !== 16'd0) $display("FAIL mid_counts: got %0d %0d want 0 0", bus.sent_count, bus.recv_count); else pass_count++;
    check_count++; if (bus.send_ready !== 1'b1 || bus.recv_valid !== 1'b0) $display("FAIL mid_flags: ready %b valid %b want 1 0", bus.send_ready, bus.recv_valid); else pass_count++;
    reset = 1'b0; bus.send_valid = 1'b0; bus.in_req = 1'b0;
    tick(); tick(); tick();
    check_count++; if (bus.out_req !== 1'b0) $display("FAIL mid_abandon_tx: out_req got %b want 0", bus.out_req); else pass_count++;
    check_count++; if (bus.recv_valid !== 1'b0 || bus.recv_count !== 16'd0) $display("FAIL mid_abandon_rx: valid %b count %0d want 0 0", bus.recv_valid, bus.recv_count); else pass_count++;
    $display("reset mid-handshake: in-flight flits abandoned");
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_tx_backpressure();
    test_rx_backpressure();
    test_counter_wrap();
    test_random_traffic();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
